keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Front end for the microwave's control inputs: scans a 4x4 key matrix, debounces it, and reports at most one key at a time.
- Drives the `keypad[0:9]` one-hot bus and the `startn`/`stopn`/`clearn` levels that the timer controller and magnetron logic consume.
- Runs on the same 100 Hz system clock. Replaces direct wiring of discrete switches.

Parameters:
- SETTLE, 1: extra cycles a row is driven before its columns are sampled; each row lasts SETTLE+1 cycles.
- DEB_COUNT, 3: consecutive matching samples needed to accept a press, and again to accept a release (minimum 1).

Ports:
- clk_100Hz  input  1  system clock; all logic on rising edge.
- clear  input  1  synchronous active-high reset.
- col_sense  input  4  matrix columns, active-low (externally pulled up), already synchronised.
- row_drive  output  4  matrix rows, active-low, exactly one row low at any time.
- keypad  output  10  one-hot digit levels, bit index = digit, held while the digit key is held.
- startn  output  1  active-low level while START is held.
- stopn  output  1  active-low level while STOP is held.
- clearn  output  1  active-low level while CLEAR is held.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_code  output  4  matrix code of the last accepted key; held until the next accepted press.

Behaviour:
- Interface: one clock (`clk_100Hz`); reset `clear` is synchronous and active-high.
- Reset values:
  - `row_drive` = 4'b1110 (row 0), state SCAN, counters 0.
  - `keypad` = 0, `startn` = `stopn` = `clearn` = 1.
  - `key_valid` = 0, `key_code` = 0.
- Asserting `clear` mid-operation returns everything to reset values on the next edge. Any held key must then be re-debounced from SCAN.
- Key code: code = 4*row + col, where col is the index of the low `col_sense` bit. Mapping:
  - row 0: 1, 2, 3, START
  - row 1: 4, 5, 6, STOP
  - row 2: 7, 8, 9, CLEAR
  - row 3: STAR, 0, HASH, NONE
  - STAR, HASH and NONE produce `key_valid`/`key_code` only; they drive no level outputs.
- All outputs are registered.
- SCAN state:
  - Drive the current row for SETTLE+1 cycles, then sample `col_sense` on the last cycle.
  - Exactly one bit low: latch row and column, counter = 1, go to DEBOUNCE. `row_drive` stays frozen.
  - No bits low, or more than one bit low (ghost/multi-key): advance to the next row (0→1→2→3→0) and stay in SCAN.
- DEBOUNCE state (row frozen, sample every cycle):
  - Sample equals the latched pattern: counter+1.
  - Any other pattern: counter = 0, advance row, back to SCAN.
  - Counter reaches DEB_COUNT: go to HELD.
  - On the HELD-entry edge: `key_valid` = 1 for exactly one cycle, `key_code` updated, mapped level output asserted in the same cycle.
  - Press-to-`key_valid` latency from the first qualifying sample: DEB_COUNT-1 cycles.
- HELD state (row frozen, sample every cycle):
  - Latched column bit high: release counter+1.
  - Latched bit low: release counter = 0 (release bounce).
  - Presses in other rows are not observed. Extra columns going low in the same row are ignored while the latched bit stays low.
  - Release counter reaches DEB_COUNT: deassert level outputs on that edge, advance to the next row, go to SCAN.
- Invariants: at most one of `keypad`/`startn`/`stopn`/`clearn` is active at any time. No second `key_valid` occurs without an intervening accepted release.
- DEB_COUNT = 1 degenerates to accept-on-first-sample; release is still required before any new press.

Decomposition:
- Shared package `keypad_pkg`:
  - state enum {SCAN, DEBOUNCE, HELD}
  - key code constants (KEY_START = 3, KEY_STOP = 7, KEY_CLEAR = 11, KEY_STAR = 12, KEY_0 = 13, KEY_HASH = 14, KEY_NONE = 15)
  - a function mapping code→digit index
- One sub-module `keypad_map`: combinational, code→{keypad one-hot, startn, stopn, clearn}. It is registered by the parent.

Test Plan:
1. Reset then idle, `col_sense` = 4'hF → `row_drive` cycles 1110, 1101, 1011, 0111, changing every 2 cycles; all outputs at reset values.
2. Press digit 5 (row 1, col 1) cleanly with DEB_COUNT = 3 → `row_drive` freezes at 1101; `key_valid` pulses once; `key_code` = 5; `keypad` = bit 5 only while held; released 3 cycles after key-up.
3. Bouncing START: col 3 toggles low/high/low in row 0 → no `key_valid` until 3 consecutive lows; then `startn` = 0 and `key_code` = 3; one `key_valid` only.
4. Ghost input: cols 0 and 2 low together in row 2 → no DEBOUNCE entry, scan continues, no outputs change.
5. Hold CLEAR, then press 0 in row 3 → `clearn` stays 0; `key_code` stays 11; no second pulse. Release CLEAR while 0 is still held → after release, 0 is accepted on its next scan (`keypad` bit 0 set).
6. `clear` asserted while in HELD with digit 9 → next edge: `keypad` = 0, `row_drive` = 1110. The still-held 9 is re-accepted after scan reaches row 2 and DEB_COUNT samples pass.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and key codes for the 4x4 keypad front end.
// Matrix code is 4*row + col; digits map to their one-hot keypad bit.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [3:0] KEY_START = 4'd3;
  localparam logic [3:0] KEY_STOP  = 4'd7;
  localparam logic [3:0] KEY_CLEAR = 4'd11;
  localparam logic [3:0] KEY_STAR  = 4'd12;
  localparam logic [3:0] KEY_0     = 4'd13;
  localparam logic [3:0] KEY_HASH  = 4'd14;
  localparam logic [3:0] KEY_NONE  = 4'd15;

  // Returns the digit value for a digit key, or 4'hF for any other key.
  function automatic logic [3:0] code_to_digit(input logic [3:0] code);
    case (code)
      4'd0:      return 4'd1;
      4'd1:      return 4'd2;
      4'd2:      return 4'd3;
      4'd4:      return 4'd4;
      4'd5:      return 4'd5;
      4'd6:      return 4'd6;
      4'd8:      return 4'd7;
      4'd9:      return 4'd8;
      4'd10:     return 4'd9;
      KEY_0:     return 4'd0;
      KEY_STAR,
      KEY_HASH,
      KEY_NONE:  return 4'hF;
      default:   return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/keypad_map.sv
// Combinational decode of a matrix key code into the digit one-hot and
// the active-low START/STOP/CLEAR levels; the parent registers the result.
module keypad_map
  import keypad_pkg::*;
(
  input  logic [3:0] code,
  output logic [9:0] keypad,
  output logic       startn,
  output logic       stopn,
  output logic       clearn
);

  logic [3:0] digit;

  always_comb begin
    digit  = code_to_digit(code);
    keypad = '0;
    if (digit != 4'hF) keypad = 10'd1 << digit;
    startn = (code != KEY_START);
    stopn  = (code != KEY_STOP);
    clearn = (code != KEY_CLEAR);
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low key matrix, debounces press and release, and
// reports one key at a time; key_valid lands DEB_COUNT-1 cycles after the first good sample.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE    = 1,
  parameter int DEB_COUNT = 3
) (
  input  logic       clk_100Hz,
  input  logic       clear,
  input  logic [3:0] col_sense,
  output logic [3:0] row_drive,
  output logic [9:0] keypad,
  output logic       startn,
  output logic       stopn,
  output logic       clearn,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int CW = $clog2(DEB_COUNT + 1);

  state_t          state;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic [3:0]      col_pat;
  logic [SW-1:0]   settle_cnt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;

  logic [3:0]      col_low;
  logic            single_low;
  logic [1:0]      low_idx;
  logic            sample_now;
  logic            accept;
  logic            release_done;
  logic [3:0]      cur_code;

  logic [9:0]      map_keypad;
  logic            map_startn;
  logic            map_stopn;
  logic            map_clearn;

  assign col_low  = ~col_sense;
  assign cnt_inc  = cnt + CW'(1);
  assign cur_code = {row_idx, low_idx};

  always_comb begin
    single_low = 1'b1;
    low_idx    = 2'd0;
    case (col_low)
      4'b0001: low_idx = 2'd0;
      4'b0010: low_idx = 2'd1;
      4'b0100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  // Accept can come straight from SCAN when a single sample suffices.
  always_comb begin
    sample_now   = (state == SCAN) && (settle_cnt == SW'(SETTLE));
    accept       = 1'b0;
    release_done = 1'b0;
    if (sample_now && single_low && (DEB_COUNT == 1))
      accept = 1'b1;
    if ((state == DEBOUNCE) && (col_sense == col_pat) && (cnt_inc == CW'(DEB_COUNT)))
      accept = 1'b1;
    if ((state == HELD) && col_sense[col_idx] && (cnt_inc == CW'(DEB_COUNT)))
      release_done = 1'b1;
  end

  keypad_map u_map (
    .code   (cur_code),
    .keypad (map_keypad),
    .startn (map_startn),
    .stopn  (map_stopn),
    .clearn (map_clearn)
  );

  always_ff @(posedge clk_100Hz) begin
    if (clear) begin
      state      <= SCAN;
      row_idx    <= 2'd0;
      row_drive  <= 4'b1110;
      col_idx    <= 2'd0;
      col_pat    <= 4'hF;
      settle_cnt <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (sample_now) begin
            settle_cnt <= '0;
            if (single_low) begin
              col_idx <= low_idx;
              col_pat <= col_sense;
              if (accept) begin
                state <= HELD;
                cnt   <= '0;
              end else begin
                state <= DEBOUNCE;
                cnt   <= CW'(1);
              end
            end else begin
              row_idx   <= row_idx + 2'd1;
              row_drive <= {row_drive[2:0], row_drive[3]};
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        DEBOUNCE: begin
          if (col_sense != col_pat) begin
            state     <= SCAN;
            cnt       <= '0;
            row_idx   <= row_idx + 2'd1;
            row_drive <= {row_drive[2:0], row_drive[3]};
          end else if (accept) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD: begin
          // Only the latched column matters; other columns in the row are ignored.
          if (!col_sense[col_idx]) begin
            cnt <= '0;
          end else if (release_done) begin
            state     <= SCAN;
            cnt       <= '0;
            row_idx   <= row_idx + 2'd1;
            row_drive <= {row_drive[2:0], row_drive[3]};
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  always_ff @(posedge clk_100Hz) begin
    if (clear) begin
      keypad    <= '0;
      startn    <= 1'b1;
      stopn     <= 1'b1;
      clearn    <= 1'b1;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= cur_code;
        keypad   <= map_keypad;
        startn   <= map_startn;
        stopn    <= map_stopn;
        clearn   <= map_clearn;
      end else if (release_done) begin
        keypad <= '0;
        startn <= 1'b1;
        stopn  <= 1'b1;
        clearn <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: a behavioural key matrix feeds two scanners (DEB_COUNT 3 and 1);
// observed outputs plus a key_valid pulse count are compared with hand-derived values.
module tb_keypad_scanner;

  localparam logic [3:0] R0 = 4'b1110;
  localparam logic [3:0] R1 = 4'b1101;
  localparam logic [3:0] R2 = 4'b1011;
  localparam logic [3:0] R3 = 4'b0111;
  localparam logic [2:0] LV_IDLE  = 3'b111;
  localparam logic [2:0] LV_START = 3'b011;
  localparam logic [2:0] LV_CLEAR = 3'b110;

  logic        clk_100Hz = 1'b0;
  logic        clear;
  logic [15:0] press;

  logic [3:0]  col_sense, row_drive, key_code;
  logic [9:0]  keypad;
  logic        startn, stopn, clearn, key_valid;

  logic [3:0]  col_sense2, row_drive2, key_code2;
  logic [9:0]  keypad2;
  logic        startn2, stopn2, clearn2, key_valid2;

  int n_pass, n_total, kv_cnt, kv_cnt2;

  typedef struct {
    logic [15:0] press;
    int          n;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  always #5 clk_100Hz = ~clk_100Hz;

  keypad_scanner #(.SETTLE(1), .DEB_COUNT(3)) dut (
    .clk_100Hz (clk_100Hz), .clear (clear), .col_sense (col_sense),
    .row_drive (row_drive), .keypad (keypad), .startn (startn),
    .stopn (stopn), .clearn (clearn), .key_valid (key_valid), .key_code (key_code)
  );

  keypad_scanner #(.SETTLE(1), .DEB_COUNT(1)) dut1 (
    .clk_100Hz (clk_100Hz), .clear (clear), .col_sense (col_sense2),
    .row_drive (row_drive2), .keypad (keypad2), .startn (startn2),
    .stopn (stopn2), .clearn (clearn2), .key_valid (key_valid2), .key_code (key_code2)
  );

  // Physical matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_sense  = 4'hF;
    col_sense2 = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_drive[r])  col_sense  = col_sense  & ~press[4*r +: 4];
      if (!row_drive2[r]) col_sense2 = col_sense2 & ~press[4*r +: 4];
    end
  end

  function automatic logic [31:0] pack(input int kvc, input logic [3:0] row,
                                       input logic [9:0] kp, input logic [2:0] lv,
                                       input logic kv, input int code);
    return {8'(kvc), 2'b00, row, kp, lv, kv, 4'(code)};
  endfunction

  function automatic logic [31:0] obs1();
    return pack(kv_cnt, row_drive, keypad, {startn, stopn, clearn}, key_valid, int'(key_code));
  endfunction

  function automatic logic [31:0] obs2();
    return pack(kv_cnt2, row_drive2, keypad2, {startn2, stopn2, clearn2}, key_valid2, int'(key_code2));
  endfunction

  task automatic tick();
    @(posedge clk_100Hz);
    #1;
    if (key_valid)  kv_cnt++;
    if (key_valid2) kv_cnt2++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (kvcnt,row,keypad,levels,kv,code)", name, got, exp);
  endtask

  task automatic do_reset();
    clear = 1'b1;
    press = 16'h0;
    ticks(2);
    clear = 1'b0;
    kv_cnt = 0;
    kv_cnt2 = 0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; kv_cnt = 0; kv_cnt2 = 0;
    clear = 1'b1; press = 16'h0;

    // Idle scan, then a clean press of 5, release, then a ghost pair in row 2.
    vecs[0]  = '{16'h0000, 0, pack(0, R0, 10'h000, LV_IDLE, 1'b0, 0)};
    vecs[1]  = '{16'h0000, 1, pack(0, R0, 10'h000, LV_IDLE, 1'b0, 0)};
    vecs[2]  = '{16'h0000, 1, pack(0, R1, 10'h000, LV_IDLE, 1'b0, 0)};
    vecs[3]  = '{16'h0000, 2, pack(0, R2, 10'h000, LV_IDLE, 1'b0, 0)};
    vecs[4]  = '{16'h0000, 2, pack(0, R3, 10'h000, LV_IDLE, 1'b0, 0)};
    vecs[5]  = '{16'h0000, 2, pack(0, R0, 10'h000, LV_IDLE, 1'b0, 0)};
    vecs[6]  = '{16'h0020, 5, pack(0, R1, 10'h000, LV_IDLE, 1'b0, 0)};
    vecs[7]  = '{16'h0020, 1, pack(1, R1, 10'h020, LV_IDLE, 1'b1, 5)};
    vecs[8]  = '{16'h0020, 1, pack(1, R1, 10'h020, LV_IDLE, 1'b0, 5)};
    vecs[9]  = '{16'h0020, 3, pack(1, R1, 10'h020, LV_IDLE, 1'b0, 5)};
    vecs[10] = '{16'h0000, 2, pack(1, R1, 10'h020, LV_IDLE, 1'b0, 5)};
    vecs[11] = '{16'h0000, 1, pack(1, R2, 10'h000, LV_IDLE, 1'b0, 5)};
    vecs[12] = '{16'h0500, 2, pack(1, R3, 10'h000, LV_IDLE, 1'b0, 5)};
    vecs[13] = '{16'h0500, 8, pack(1, R3, 10'h000, LV_IDLE, 1'b0, 5)};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      press = vecs[i].press;
      ticks(vecs[i].n);
      check($sformatf("vec%0d", i), obs1(), vecs[i].exp);
    end

    // Bouncing START, including a release bounce while held.
    do_reset();
    press = 16'h0008; ticks(2);
    press = 16'h0000; ticks(1);
    check("start_bounce_drop", obs1(), pack(0, R1, 10'h000, LV_IDLE, 1'b0, 0));
    press = 16'h0008; ticks(9);
    check("start_pre_accept", obs1(), pack(0, R0, 10'h000, LV_IDLE, 1'b0, 0));
    ticks(1);
    check("start_accept", obs1(), pack(1, R0, 10'h000, LV_START, 1'b1, 3));
    press = 16'h0000; ticks(1);
    press = 16'h0008; ticks(1);
    press = 16'h0000; ticks(2);
    check("start_rel_bounce", obs1(), pack(1, R0, 10'h000, LV_START, 1'b0, 3));
    ticks(1);
    check("start_release", obs1(), pack(1, R1, 10'h000, LV_IDLE, 1'b0, 3));

    // CLEAR held masks a press of 0 in another row until CLEAR is released.
    do_reset();
    press = 16'h0800; ticks(8);
    check("clr_accept", obs1(), pack(1, R2, 10'h000, LV_CLEAR, 1'b1, 11));
    press = 16'h2800; ticks(10);
    check("clr_masks_0", obs1(), pack(1, R2, 10'h000, LV_CLEAR, 1'b0, 11));
    press = 16'h2000; ticks(3);
    check("clr_release", obs1(), pack(1, R3, 10'h000, LV_IDLE, 1'b0, 11));
    ticks(3);
    check("zero_debounce", obs1(), pack(1, R3, 10'h000, LV_IDLE, 1'b0, 11));
    ticks(1);
    check("zero_accept", obs1(), pack(2, R3, 10'h001, LV_IDLE, 1'b1, 13));

    // Digit 9 held, a same-row extra column, then clear while held.
    do_reset();
    press = 16'h0400; ticks(8);
    check("nine_accept", obs1(), pack(1, R2, 10'h200, LV_IDLE, 1'b1, 10));
    press = 16'h0600; ticks(2);
    check("nine_extra_col", obs1(), pack(1, R2, 10'h200, LV_IDLE, 1'b0, 10));
    press = 16'h0400; clear = 1'b1; ticks(1);
    check("nine_clear", obs1(), pack(1, R0, 10'h000, LV_IDLE, 1'b0, 0));
    clear = 1'b0; ticks(7);
    check("nine_redebounce", obs1(), pack(1, R2, 10'h000, LV_IDLE, 1'b0, 0));
    ticks(1);
    check("nine_reaccept", obs1(), pack(2, R2, 10'h200, LV_IDLE, 1'b1, 10));

    // DEB_COUNT = 1: accept on first sample, one-sample release, then re-press.
    do_reset();
    press = 16'h0001; ticks(1);
    check("d1_idle", obs2(), pack(0, R0, 10'h000, LV_IDLE, 1'b0, 0));
    ticks(1);
    check("d1_accept", obs2(), pack(1, R0, 10'h002, LV_IDLE, 1'b1, 0));
    ticks(1);
    check("d1_held", obs2(), pack(1, R0, 10'h002, LV_IDLE, 1'b0, 0));
    press = 16'h0000; ticks(1);
    check("d1_release", obs2(), pack(1, R1, 10'h000, LV_IDLE, 1'b0, 0));
    press = 16'h0001; ticks(8);
    check("d1_repress", obs2(), pack(2, R0, 10'h002, LV_IDLE, 1'b1, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
